cmp_stream_debounce: RTL and testbench
======================================

// Module: cmp_stream_debounce
// PURPOSE
//  Streaming, parametrised successor to the combinational word comparator.
//  Registers a per-sample a-vs-b relation (gt/lt/eq) in signed or unsigned mode behind a valid/ready handshake.
//  Tracks a debounced relation state that changes only after DEBOUNCE consecutive agreeing samples.
//  Counts debounced state changes. Sits between sample sources (ADC/counter paths) and threshold/alarm logic.
// PARAMETERS
//  WIDTH     16  operand width, bits (>=1)
//  DEBOUNCE   4  consecutive accepted samples needed to change debounced state (>=1)
//  CNT_W     16  width of saturating transition counter (>=1)
// PORTS
//  clk          in   1       single clock, all logic on rising edge
//  rst          in   1       synchronous reset, active-high
//  in_valid     in   1       input sample valid
//  in_ready     out  1       block can accept sample this cycle
//  a            in   WIDTH   operand A
//  b            in   WIDTH   operand B
//  signed_mode  in   1       1: two's-complement compare; 0: unsigned; sampled with the operands
//  out_valid    out  1       output beat valid
//  out_ready    in   1       downstream accepts beat
//  gt           out  1       raw a>b for this beat
//  lt           out  1       raw a<b for this beat
//  eq           out  1       raw a==b for this beat
//  state        out  2       debounced relation after this beat: 00=EQ 01=LT 10=GT (11 never driven)
//  state_chg    out  1       this beat caused a debounced state change
//  trans_cnt    out  CNT_W   saturating count of debounced state changes
//  clr_cnt      in   1       synchronous clear of trans_cnt
// BEHAVIOUR
//  Reset: one clock with rst=1 gives out_valid=0, gt=lt=eq=0, state=EQ, state_chg=0, trans_cnt=0,
//   candidate=EQ, run=0. rst overrides all other inputs, including mid-stream: any held beat and partial run are discarded.
//  Handshake: in_ready = !out_valid || out_ready (combinational, single output register, no skid buffer).
//   A sample is accepted when in_valid && in_ready. Latency is 1 cycle: the beat appears in out_valid the next cycle.
//   A beat is consumed when out_valid && out_ready. With no accept in the same cycle, out_valid goes to 0.
//   Accept and consume in the same cycle: the new beat replaces the old one with no bubble.
//   While stalled (out_valid && !out_ready), all beat outputs stay stable.
//   While out_valid=0, the beat outputs hold their last values.
//  Compare: with out_valid=1, exactly one of gt/lt/eq is 1.
//   The signed comparison is a full WIDTH-bit two's-complement compare with no overflow path.
//  Debounce, evaluated only on accepted samples; idle cycles do not break a run. rel is the raw relation of the sample.
//   - rel==state: run=0, candidate unchanged.
//   - rel!=state, rel==candidate: run=run+1.
//   - rel!=state, rel!=candidate: candidate=rel, run=1.
//   - If the resulting run==DEBOUNCE: state=candidate, run=0, state_chg=1 on this beat. Otherwise state_chg=0.
//   - DEBOUNCE=1: the first differing sample switches state.
//  state, state_chg and trans_cnt are registered with the beat, so they are aligned with gt/lt/eq of the same sample.
//  trans_cnt increments on each state change and saturates at 2^CNT_W-1 (no wrap).
//   clr_cnt=1 forces 0 next cycle and takes priority over a same-cycle increment.
// TESTING
//  1 W=16, signed_mode=0, a=16'h8000, b=16'h7FFF -> gt=1 one cycle after accept; same operands with signed_mode=1 -> lt=1.
//  2 D=4, beats GT,GT,GT,EQ -> state stays EQ, state_chg=0. Then GT x4 -> 4th beat state=GT, state_chg=1, trans_cnt=1.
//  3 D=4, from EQ: GT,GT,LT,GT,GT,GT -> no change. Next GT -> state=GT. in_valid gaps inside the run do not reset it.
//  4 out_ready=0 for 3 cycles, in_valid=1 -> in_ready=0, beat held stable. Release -> all samples delivered in order.
//   Out_ready=1 with continuous in_valid -> one beat per cycle.
//  5 CNT_W=2: 5 state changes -> trans_cnt=3 (saturated). clr_cnt on the same beat as a change -> trans_cnt=0.
//  6 rst mid-stream (out_valid=1, run=3 toward GT) -> next cycle out_valid=0, state=EQ, trans_cnt=0.
//   3 GT beats after reset -> no change.

Source files
------------

// File: rtl/cmp_stream_debounce.sv
// ---------------------------------------------------------------------------
// cmp_stream_debounce
//   Streaming a-vs-b comparator with a debounced relation tracker.
//   Each accepted sample is compared (signed or unsigned). The raw relation
//   is registered into a single-entry output stage behind a valid/ready
//   handshake. A debounced relation (EQ/LT/GT) changes only after DEBOUNCE
//   consecutive accepted samples agree on a new relation. Debounced changes
//   are counted in a saturating counter.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake; in_ready = !out_valid || out_ready
//   a, b            operands (WIDTH bits)
//   signed_mode     1: two's-complement compare, 0: unsigned
//   out_valid/ready output handshake, 1-cycle latency
//   gt, lt, eq      raw relation of the current beat (one-hot when valid)
//   state           debounced relation after this beat (00 EQ, 01 LT, 10 GT)
//   state_chg       this beat switched the debounced relation
//   trans_cnt       saturating count of debounced changes
//   clr_cnt         synchronous clear of trans_cnt (wins over increment)
// ---------------------------------------------------------------------------
module cmp_stream_debounce #(
  parameter int WIDTH    = 16,
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             gt,
  output logic             lt,
  output logic             eq,
  output logic [1:0]       state,
  output logic             state_chg,
  output logic [CNT_W-1:0] trans_cnt,
  input  logic             clr_cnt
);

  typedef enum logic [1:0] {
    REL_EQ = 2'b00,
    REL_LT = 2'b01,
    REL_GT = 2'b10
  } rel_e;

  // Run length never holds DEBOUNCE itself (it resets to 0 on a change),
  // but run+1 must be able to reach DEBOUNCE.
  localparam int RUN_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] DEB_V = RUN_W'(DEBOUNCE);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic             vld_q;
  logic             gt_q, lt_q, eq_q;
  rel_e             state_q, state_d;
  rel_e             cand_q,  cand_d;
  logic [RUN_W-1:0] run_q,   run_d;
  logic             chg_q,   chg_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;

  // -------------------------------------------------------------------------
  // Handshake
  // -------------------------------------------------------------------------
  logic accept, consume;

  assign in_ready = !vld_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign consume  = vld_q && out_ready;

  // -------------------------------------------------------------------------
  // Raw compare of the incoming sample
  // -------------------------------------------------------------------------
  logic gt_c, lt_c, eq_c;
  rel_e rel_c;

  always_comb begin
    eq_c = (a == b);
    if (signed_mode) gt_c = ($signed(a) > $signed(b));
    else             gt_c = (a > b);
    lt_c = !eq_c && !gt_c;
    if (eq_c)      rel_c = REL_EQ;
    else if (gt_c) rel_c = REL_GT;
    else           rel_c = REL_LT;
  end

  // -------------------------------------------------------------------------
  // Debounce next-state, only meaningful when a sample is accepted
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    run_d   = run_q;
    chg_d   = 1'b0;
    if (rel_c == state_q) begin
      // Agreement with the current state breaks any pending run.
      run_d = '0;
    end else if (rel_c == cand_q) begin
      run_d = run_q + 1'b1;
    end else begin
      cand_d = rel_c;
      run_d  = {{(RUN_W-1){1'b0}}, 1'b1};
    end
    if (run_d == DEB_V) begin
      state_d = cand_d;
      run_d   = '0;
      chg_d   = 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Transition counter: clear wins, otherwise saturating increment
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)
      cnt_d = '0;
    else if (accept && chg_d && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
      eq_q    <= 1'b0;
      state_q <= REL_EQ;
      cand_q  <= REL_EQ;
      run_q   <= '0;
      chg_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      if (accept) begin
        // New beat loads (also covers same-cycle consume: no bubble).
        vld_q   <= 1'b1;
        gt_q    <= gt_c;
        lt_q    <= lt_c;
        eq_q    <= eq_c;
        state_q <= state_d;
        cand_q  <= cand_d;
        run_q   <= run_d;
        chg_q   <= chg_d;
      end else if (consume) begin
        // Beat fields hold their last values while idle.
        vld_q <= 1'b0;
      end
      cnt_q <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign out_valid = vld_q;
  assign gt        = gt_q;
  assign lt        = lt_q;
  assign eq        = eq_q;
  assign state     = state_q;
  assign state_chg = chg_q;
  assign trans_cnt = cnt_q;

endmodule

// File: tb/tb_cmp_stream_debounce.sv
// Bench for cmp_stream_debounce. Two instances share stimulus:
//   dut  : WIDTH=16, DEBOUNCE=4, CNT_W=16
//   dut2 : WIDTH=16, DEBOUNCE=1, CNT_W=2 (saturation / single-sample switch)
module tb_cmp_stream_debounce;

  logic        clk = 1'b0;
  logic        rst, in_valid, signed_mode, out_ready, clr_cnt;
  logic [15:0] a, b;

  logic        in_ready, out_valid, gt, lt, eq, state_chg;
  logic [1:0]  state;
  logic [15:0] trans_cnt;

  logic        in_ready2, out_valid2, gt2, lt2, eq2, state_chg2;
  logic [1:0]  state2;
  logic [1:0]  trans_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cmp_stream_debounce #(.WIDTH(16), .DEBOUNCE(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .gt(gt), .lt(lt), .eq(eq), .state(state), .state_chg(state_chg),
    .trans_cnt(trans_cnt), .clr_cnt(clr_cnt)
  );

  cmp_stream_debounce #(.WIDTH(16), .DEBOUNCE(1), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .signed_mode(signed_mode),
    .out_valid(out_valid2), .out_ready(out_ready),
    .gt(gt2), .lt(lt2), .eq(eq2), .state(state2), .state_chg(state_chg2),
    .trans_cnt(trans_cnt2), .clr_cnt(clr_cnt)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [2:0]  rel;   // {gt,lt,eq}
    logic [1:0]  st;
    logic        chg;
    logic [15:0] cnt;
    logic [1:0]  st2;
    logic [1:0]  cnt2;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic beat(input logic [15:0] av, input logic [15:0] bv, input logic sm);
    a = av; b = bv; signed_mode = sm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    // EQ=00 LT=01 GT=10
    tbl[0]  = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 2'b00, 1'b0, 16'd0, 2'b10, 2'd1};
    tbl[1]  = '{16'h8000, 16'h7FFF, 1'b1, 3'b010, 2'b00, 1'b0, 16'd0, 2'b01, 2'd2};
    tbl[2]  = '{16'h0005, 16'h0005, 1'b0, 3'b001, 2'b00, 1'b0, 16'd0, 2'b00, 2'd3};
    tbl[3]  = '{16'h000A, 16'h0003, 1'b0, 3'b100, 2'b00, 1'b0, 16'd0, 2'b10, 2'd3};
    tbl[4]  = '{16'h000A, 16'h0003, 1'b0, 3'b100, 2'b00, 1'b0, 16'd0, 2'b10, 2'd3};
    tbl[5]  = '{16'h000A, 16'h0003, 1'b0, 3'b100, 2'b00, 1'b0, 16'd0, 2'b10, 2'd3};
    tbl[6]  = '{16'h0007, 16'h0007, 1'b0, 3'b001, 2'b00, 1'b0, 16'd0, 2'b00, 2'd3};
    tbl[7]  = '{16'h000A, 16'h0003, 1'b0, 3'b100, 2'b00, 1'b0, 16'd0, 2'b10, 2'd3};
    tbl[8]  = '{16'h000A, 16'h0003, 1'b0, 3'b100, 2'b00, 1'b0, 16'd0, 2'b10, 2'd3};
    tbl[9]  = '{16'h000A, 16'h0003, 1'b0, 3'b100, 2'b00, 1'b0, 16'd0, 2'b10, 2'd3};
    tbl[10] = '{16'h000A, 16'h0003, 1'b0, 3'b100, 2'b10, 1'b1, 16'd1, 2'b10, 2'd3};
    tbl[11] = '{16'h0003, 16'h000A, 1'b0, 3'b010, 2'b10, 1'b0, 16'd1, 2'b01, 2'd3};
    tbl[12] = '{16'hFFFF, 16'h0001, 1'b1, 3'b010, 2'b10, 1'b0, 16'd1, 2'b01, 2'd3};
    tbl[13] = '{16'hFFFF, 16'h0001, 1'b0, 3'b100, 2'b10, 1'b0, 16'd1, 2'b10, 2'd3};
    tbl[14] = '{16'h0000, 16'h0001, 1'b0, 3'b010, 2'b10, 1'b0, 16'd1, 2'b01, 2'd3};
    tbl[15] = '{16'h0000, 16'h0001, 1'b0, 3'b010, 2'b10, 1'b0, 16'd1, 2'b01, 2'd3};
    tbl[16] = '{16'h0000, 16'h0001, 1'b0, 3'b010, 2'b10, 1'b0, 16'd1, 2'b01, 2'd3};
    tbl[17] = '{16'h0000, 16'h0001, 1'b0, 3'b010, 2'b01, 1'b1, 16'd2, 2'b01, 2'd3};
    tbl[18] = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 2'b01, 1'b0, 16'd2, 2'b10, 2'd3};
    tbl[19] = '{16'h8000, 16'h8000, 1'b1, 3'b001, 2'b01, 1'b0, 16'd2, 2'b00, 2'd3};

    rst = 1'b1; in_valid = 1'b0; signed_mode = 1'b0; out_ready = 1'b1;
    clr_cnt = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rel",       {29'd0, gt, lt, eq}, 32'd0);
    chk("rst_state",     {30'd0, state}, 32'd0);
    chk("rst_chg",       {31'd0, state_chg}, 32'd0);
    chk("rst_cnt",       {16'd0, trans_cnt}, 32'd0);
    chk("rst_cnt2",      {30'd0, trans_cnt2}, 32'd0);

    // Table-driven stream, one beat per cycle
    for (int i = 0; i < 20; i++) begin
      beat(tbl[i].a, tbl[i].b, tbl[i].sm);
      chk($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_rel", i),   {29'd0, gt, lt, eq}, {29'd0, tbl[i].rel});
      chk($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, tbl[i].st});
      chk($sformatf("v%0d_chg", i),   {31'd0, state_chg}, {31'd0, tbl[i].chg});
      chk($sformatf("v%0d_cnt", i),   {16'd0, trans_cnt}, {16'd0, tbl[i].cnt});
      chk($sformatf("v%0d_state2", i), {30'd0, state2}, {30'd0, tbl[i].st2});
      chk($sformatf("v%0d_cnt2", i),  {30'd0, trans_cnt2}, {30'd0, tbl[i].cnt2});
    end

    // Clear on the same beat as a change: clear wins
    clr_cnt = 1'b1;
    beat(16'h000A, 16'h0003, 1'b0);
    clr_cnt = 1'b0;
    chk("clr_chg2",  {31'd0, state_chg2}, 32'd1);
    chk("clr_state2", {30'd0, state2}, 32'd2);
    chk("clr_cnt2",  {30'd0, trans_cnt2}, 32'd0);
    chk("clr_cnt",   {16'd0, trans_cnt}, 32'd0);

    // Backpressure: held beat stays stable, in_ready low
    out_ready = 1'b0;
    a = 16'd1; b = 16'd2; signed_mode = 1'b0; in_valid = 1'b1;
    #1;
    chk("stall_in_ready0", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("stall%0d_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stall%0d_rel", k),   {29'd0, gt, lt, eq}, 32'b100);
      chk($sformatf("stall%0d_rdy", k),   {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("order_x_rel",   {29'd0, gt, lt, eq}, 32'b010);
    chk("order_x_state2", {30'd0, state2}, 32'd1);
    chk("order_x_cnt2",  {30'd0, trans_cnt2}, 32'd1);
    a = 16'd4; b = 16'd4;
    @(posedge clk); #1;
    chk("order_y_rel", {29'd0, gt, lt, eq}, 32'b001);
    chk("order_y_valid", {31'd0, out_valid}, 32'd1);
    a = 16'd9; b = 16'd2;
    @(posedge clk); #1;
    chk("order_z_rel", {29'd0, gt, lt, eq}, 32'b100);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_hold",  {29'd0, gt, lt, eq}, 32'b100);

    // Reset mid-stream discards beat and partial run
    do_reset;
    for (int k = 0; k < 3; k++) beat(16'h000A, 16'h0003, 1'b0);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("pre_rst_state", {30'd0, state}, 32'd0);
    a = 16'h000A; b = 16'h0003; in_valid = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_state", {30'd0, state}, 32'd0);
    chk("mid_rst_cnt",   {16'd0, trans_cnt}, 32'd0);
    chk("mid_rst_rel",   {29'd0, gt, lt, eq}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      beat(16'h000A, 16'h0003, 1'b0);
      chk($sformatf("post_rst%0d_state", k), {30'd0, state}, 32'd0);
      chk($sformatf("post_rst%0d_chg", k),   {31'd0, state_chg}, 32'd0);
    end

    // Candidate restart and idle gaps inside a run
    do_reset;
    beat(16'h000A, 16'h0003, 1'b0); idle(2);
    chk("gap_g1_state", {30'd0, state}, 32'd0);
    beat(16'h000A, 16'h0003, 1'b0); idle(2);
    beat(16'h0003, 16'h000A, 1'b0); idle(2);
    chk("gap_l_state", {30'd0, state}, 32'd0);
    beat(16'h000A, 16'h0003, 1'b0); idle(1);
    beat(16'h000A, 16'h0003, 1'b0); idle(3);
    beat(16'h000A, 16'h0003, 1'b0);
    chk("gap_g3_state", {30'd0, state}, 32'd0);
    chk("gap_g3_chg",   {31'd0, state_chg}, 32'd0);
    idle(2);
    beat(16'h000A, 16'h0003, 1'b0);
    chk("gap_g4_state", {30'd0, state}, 32'd2);
    chk("gap_g4_chg",   {31'd0, state_chg}, 32'd1);
    chk("gap_g4_cnt",   {16'd0, trans_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
